// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrl_state_t;
endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry adder, purely combinational.
module nibble_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);
  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/adder_share_ctrl.sv
// Two-requester round-robin front end that runs wide adds
// nibble-serially through one shared 4-bit adder.
module adder_share_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  localparam int NUM_NIB = WIDTH / NIBBLE_W;
  localparam int IDX_W =
    (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_NIB - 1);

  ctrl_state_t      state_q, state_d;
  logic             last_id_q, last_id_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_id_q, rsp_id_d;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;
  logic                idle;

  assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_adder u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Pointer gives the tie to whoever was not served last.
  assign idle = (state_q == IDLE);
  assign req0_ready = ~rst & idle & req0_valid &
                      (~req1_valid | last_id_q);
  assign req1_ready = ~rst & idle & req1_valid &
                      (~req0_valid | ~last_id_q);

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_id_d   = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready) begin
          a_d       = req0_a;
          b_d       = req0_b;
          carry_d   = req0_cin;
          id_d      = 1'b0;
          last_id_d = 1'b0;
          idx_d     = '0;
          state_d   = RUN;
        end else if (req1_ready) begin
          a_d       = req1_a;
          b_d       = req1_b;
          carry_d   = req1_cin;
          id_d      = 1'b1;
          last_id_d = 1'b1;
          idx_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        result_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_sum;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        // Response registers update only here so they
        // hold steady between completions.
        if (idx_q == LAST_IDX) begin
          idx_d      = '0;
          state_d    = DONE;
          rsp_sum_d  = result_d;
          rsp_cout_d = nib_cout;
          rsp_id_d   = id_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_id_q  <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_id_q  <= last_id_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_id_q   <= rsp_id_d;
    end
  end
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl (WIDTH 16 and 4).
module tb_adder_share_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        r0v = 0, r1v = 0, r0r, r1r;
  logic [15:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
  logic        r0c = 0, r1c = 0;
  logic        rv, rid, rcout, rbusy;
  logic [15:0] rsum;

  adder_share_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r),
    .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
    .req1_valid(r1v), .req1_ready(r1r),
    .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
    .rsp_valid(rv), .rsp_id(rid),
    .rsp_sum(rsum), .rsp_cout(rcout),
    .busy(rbusy)
  );

  logic       wv = 0, wr, w1r;
  logic [3:0] wa = 0, wb = 0;
  logic       wc = 0;
  logic       wrv, wrid, wcout, wbusy;
  logic [3:0] wsum;

  adder_share_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(wv), .req0_ready(wr),
    .req0_a(wa), .req0_b(wb), .req0_cin(wc),
    .req1_valid(1'b0), .req1_ready(w1r),
    .req1_a(4'h0), .req1_b(4'h0), .req1_cin(1'b0),
    .rsp_valid(wrv), .rsp_id(wrid),
    .rsp_sum(wsum), .rsp_cout(wcout),
    .busy(wbusy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] sum;
    logic        cout;
    int          hs;
  } exp_t;
  exp_t sb[$];

  bit chk_rr = 0;
  bit rr_exp = 0;
  int last_hs = -1;
  logic prev_rv = 0;

  always @(negedge clk) begin
    if (!rst) chk("rdy_excl", {31'd0, r0r & r1r}, 0);
    if (rv) begin
      chk("rsp_pulse", {31'd0, prev_rv}, 0);
      chk("busy_done", {31'd0, rbusy}, 1);
      if (sb.size() == 0) begin
        chk("rsp_unexp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", {31'd0, rid}, {31'd0, e.id});
        chk("rsp_sum", {16'd0, rsum}, {16'd0, e.sum});
        chk("rsp_cout", {31'd0, rcout}, {31'd0, e.cout});
        chk("rsp_lat", cyc - e.hs, 5);
      end
    end
    prev_rv = rv;
  end

  task automatic set_req(input bit id,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic c);
    if (id == 0) begin
      r0a = a; r0b = b; r0c = c; r0v = 1;
    end else begin
      r1a = a; r1b = b; r1c = c; r1v = 1;
    end
  endtask

  task automatic wait_hs(input bit id,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic c);
    logic [16:0] full;
    exp_t e;
    bit got = 0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if ((id == 0 && r0r) || (id == 1 && r1r)) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk("rdy_timeout", {31'd0, id}, 32'hFFFF);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {16'd0, c};
      e.id = id;
      e.sum = full[15:0];
      e.cout = full[16];
      e.hs = cyc;
      sb.push_back(e);
      if (chk_rr) begin
        chk("rr_id", {31'd0, id}, {31'd0, rr_exp});
        rr_exp = ~rr_exp;
        if (last_hs >= 0) chk("hs_gap", cyc - last_hs, 6);
        last_hs = cyc;
      end
    end
  endtask

  task automatic drop(input bit id);
    @(posedge clk);
    #1;
    if (id == 0) r0v = 0;
    else r1v = 0;
  endtask

  task automatic send(input bit id,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic c);
    @(negedge clk);
    set_req(id, a, b, c);
    wait_hs(id, a, b, c);
    drop(id);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++)
      @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int t0;
    bit got;
    #3;
    chk("rst_rv", {31'd0, rv}, 0);
    chk("rst_sum", {16'd0, rsum}, 0);
    chk("rst_busy", {31'd0, rbusy}, 0);
    chk("rst_id", {31'd0, rid}, 0);
    set_req(0, 16'h1111, 16'h2222, 0);
    set_req(1, 16'h8000, 16'h8000, 0);
    #1;
    chk("rst_rdy0", {31'd0, r0r}, 0);
    chk("rst_rdy1", {31'd0, r1r}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk_rr = 1;
    fork
      begin
        wait_hs(0, 16'h1111, 16'h2222, 0);
        drop(0);
        send(0, 16'hABCD, 16'h1234, 1);
      end
      begin
        wait_hs(1, 16'h8000, 16'h8000, 0);
        drop(1);
        send(1, 16'h00FF, 16'h0F01, 1);
      end
    join
    chk_rr = 0;
    drain();

    send(0, 16'h1234, 16'h0FFF, 0);
    drain();
    send(1, 16'hFFFF, 16'h0001, 0);
    drain();
    send(0, 16'h0000, 16'h0000, 1);
    drain();

    @(negedge clk);
    set_req(0, 16'h5A5A, 16'h3C3C, 1);
    wait_hs(0, 16'h5A5A, 16'h3C3C, 1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    sb.delete();
    chk("mid_rv", {31'd0, rv}, 0);
    chk("mid_sum", {16'd0, rsum}, 0);
    chk("mid_busy", {31'd0, rbusy}, 0);
    chk("mid_rdy0", {31'd0, r0r}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    set_req(0, 16'h5A5A, 16'h3C3C, 1);
    wait_hs(0, 16'h5A5A, 16'h3C3C, 1);
    drop(0);
    drain();

    @(negedge clk);
    wa = 4'hF; wb = 4'hF; wc = 1; wv = 1;
    #1;
    chk("w4_rdy", {31'd0, wr}, 1);
    t0 = cyc;
    @(posedge clk);
    #1;
    wv = 0;
    got = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (wrv) begin
        got = 1;
        break;
      end
    end
    chk("w4_rv", {31'd0, got}, 1);
    chk("w4_lat", cyc - t0, 2);
    chk("w4_sum", {28'd0, wsum}, 32'hF);
    chk("w4_cout", {31'd0, wcout}, 1);
    chk("w4_id", {31'd0, wrid}, 0);
    @(negedge clk);
    chk("w4_pulse", {31'd0, wrv}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
